// File: rtl/read_and_write_if.sv
// read_and_write_if
//   Register-file access bundle: two independent combinational read ports and
//   one synchronous write port.
//   Parameters: DATA_W (register width), ADDR_W (register-number width).
//   Signals:
//     ReadRegNum1/2 : register number for read port 1/2 (master -> slave)
//     ReadOut1/2    : contents of the selected register   (slave -> master)
//     WriteEn       : write enable                        (master -> slave)
//     WriteRegNum   : destination register number         (master -> slave)
//     RegData       : write data                          (master -> slave)
interface read_and_write_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] ReadRegNum1;
  logic [ADDR_W-1:0] ReadRegNum2;
  logic [DATA_W-1:0] ReadOut1;
  logic [DATA_W-1:0] ReadOut2;
  logic              WriteEn;
  logic [ADDR_W-1:0] WriteRegNum;
  logic [DATA_W-1:0] RegData;

  modport master (
    output ReadRegNum1, ReadRegNum2, WriteEn, WriteRegNum, RegData,
    input  ReadOut1, ReadOut2
  );

  modport slave (
    input  ReadRegNum1, ReadRegNum2, WriteEn, WriteRegNum, RegData,
    output ReadOut1, ReadOut2
  );
endinterface

// File: rtl/read_and_write.sv
// read_and_write
//   2**ADDR_W x DATA_W register file with register 0 hardwired to zero.
//   Two fully independent combinational read ports, one write port written on
//   the rising Clk edge when WriteEn=1.
//   Ports:
//     Clk    : rising-edge clock for register writes
//     ResetN : asynchronous active-low reset, clears every register
//     bus    : read_and_write_if.slave (read/write port signals)
//   Build option:
//     REGFILE_BYPASS_EN defined   -> a read port addressing the register being
//                                    written this cycle returns RegData directly.
//     REGFILE_BYPASS_EN undefined -> reads return the stored value until the edge.
module read_and_write #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic             Clk,
  input logic             ResetN,
  read_and_write_if.slave bus
);

  localparam int unsigned REG_CNT = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [REG_CNT];

  // Register 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      regs <= '{default: '0};
    end else if (bus.WriteEn && (bus.WriteRegNum != '0)) begin
      regs[bus.WriteRegNum] <= bus.RegData;
    end
  end

  logic [DATA_W-1:0] stored1;
  logic [DATA_W-1:0] stored2;

  always_comb begin
    stored1 = '0;
    stored2 = '0;
    if (bus.ReadRegNum1 != '0) stored1 = regs[bus.ReadRegNum1];
    if (bus.ReadRegNum2 != '0) stored2 = regs[bus.ReadRegNum2];
  end

`ifdef REGFILE_BYPASS_EN
  logic fwdValid;

  // Forwarding is gated by ResetN so reads stay zero while reset is held.
  always_comb begin
    fwdValid     = ResetN && bus.WriteEn && (bus.WriteRegNum != '0);
    bus.ReadOut1 = stored1;
    bus.ReadOut2 = stored2;
    if (fwdValid && (bus.ReadRegNum1 == bus.WriteRegNum)) bus.ReadOut1 = bus.RegData;
    if (fwdValid && (bus.ReadRegNum2 == bus.WriteRegNum)) bus.ReadOut2 = bus.RegData;
  end
`else
  always_comb begin
    bus.ReadOut1 = stored1;
    bus.ReadOut2 = stored2;
  end
`endif

endmodule

// File: tb/tb_read_and_write.sv
// tb_read_and_write
//   Directed self-checking bench for read_and_write (default DATA_W=32, ADDR_W=5).
module tb_read_and_write;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic Clk;
  logic ResetN;

  read_and_write_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  read_and_write #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .Clk    (Clk),
    .ResetN (ResetN),
    .bus    (bus)
  );

  int assertCount = 0;
  int failCount   = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkEq(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs may then change safely.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic setWrite(input logic en, input logic [ADDR_W-1:0] num,
                          input logic [DATA_W-1:0] data);
    bus.WriteEn     = en;
    bus.WriteRegNum = num;
    bus.RegData     = data;
  endtask

  task automatic setRead(input logic [ADDR_W-1:0] n1, input logic [ADDR_W-1:0] n2);
    bus.ReadRegNum1 = n1;
    bus.ReadRegNum2 = n2;
    #1;
  endtask

  initial begin
    ResetN = 1'b0;
    setWrite(1'b0, '0, '0);
    bus.ReadRegNum1 = '0;
    bus.ReadRegNum2 = '0;

    // Writes attempted while reset is held must be ignored.
    #2;
    setWrite(1'b1, 5'd5, 32'h0000_00AA);
    tick();
    tick();
    setRead(5'd5, 5'd9);
    checkEq("rst_hold_rd1", bus.ReadOut1, 32'h0);
    checkEq("rst_hold_rd2", bus.ReadOut2, 32'h0);
    setWrite(1'b0, '0, '0);
    ResetN = 1'b1;

    // Reset state
    setRead(5'd9, 5'd28);
    checkEq("reset_r9", bus.ReadOut1, 32'h0);
    checkEq("reset_r28", bus.ReadOut2, 32'h0);

    // Basic write
    setWrite(1'b1, 5'd4, 32'd75);
    tick();
    setWrite(1'b0, '0, '0);
    setRead(5'd4, 5'd28);
    checkEq("wr_r4", bus.ReadOut1, 32'd75);
    checkEq("wr_r28", bus.ReadOut2, 32'h0);

    // Register 0 is hardwired
    setWrite(1'b1, 5'd0, 32'hFFFF_FFFF);
    tick();
    setWrite(1'b0, '0, '0);
    setRead(5'd0, 5'd0);
    checkEq("r0_rd1", bus.ReadOut1, 32'h0);
    checkEq("r0_rd2", bus.ReadOut2, 32'h0);

    // Top register, then hold with WriteEn=0
    setWrite(1'b1, 5'd31, 32'hDEAD_BEEF);
    tick();
    setWrite(1'b0, 5'd31, 32'h1234_5678);
    tick();
    tick();
    tick();
    setRead(5'd31, 5'd4);
    checkEq("hold_r31", bus.ReadOut1, 32'hDEAD_BEEF);
    checkEq("hold_r4", bus.ReadOut2, 32'd75);
    setRead(5'd31, 5'd31);
    checkEq("same_reg_rd1", bus.ReadOut1, 32'hDEAD_BEEF);
    checkEq("same_reg_rd2", bus.ReadOut2, 32'hDEAD_BEEF);

    // Read during write to the same register
    setWrite(1'b1, 5'd4, 32'd99);
    setRead(5'd4, 5'd9);
`ifdef REGFILE_BYPASS_EN
    checkEq("rdw_pre_edge", bus.ReadOut1, 32'd99);
`else
    checkEq("rdw_pre_edge", bus.ReadOut1, 32'd75);
`endif
    checkEq("rdw_other_port", bus.ReadOut2, 32'h0);
    tick();
    setWrite(1'b0, '0, '0);
    setRead(5'd4, 5'd31);
    checkEq("rdw_post_edge", bus.ReadOut1, 32'd99);
    checkEq("rdw_r31_kept", bus.ReadOut2, 32'hDEAD_BEEF);

    // Back-to-back writes, one per cycle
    setWrite(1'b1, 5'd9, 32'h0000_0011);
    tick();
    setWrite(1'b1, 5'd10, 32'h0000_0022);
    tick();
    setWrite(1'b0, '0, '0);
    setRead(5'd9, 5'd10);
    checkEq("b2b_r9", bus.ReadOut1, 32'h0000_0011);
    checkEq("b2b_r10", bus.ReadOut2, 32'h0000_0022);
    setRead(5'd4, 5'd11);
    checkEq("b2b_r4_kept", bus.ReadOut1, 32'd99);
    checkEq("b2b_r11_untouched", bus.ReadOut2, 32'h0);

    // Async reset pulse between edges clears immediately
    tick();
    setRead(5'd4, 5'd9);
    ResetN = 1'b0;
    #1;
    checkEq("async_rst_r4", bus.ReadOut1, 32'h0);
    checkEq("async_rst_r9", bus.ReadOut2, 32'h0);
    ResetN = 1'b1;
    #1;
    checkEq("post_pulse_r4", bus.ReadOut1, 32'h0);

    // Reset held across a write edge wins
    setWrite(1'b1, 5'd7, 32'h0000_0055);
    ResetN = 1'b0;
    tick();
    ResetN = 1'b1;
    setWrite(1'b0, '0, '0);
    setRead(5'd7, 5'd31);
    checkEq("rst_mid_wr_r7", bus.ReadOut1, 32'h0);
    checkEq("rst_mid_wr_r31", bus.ReadOut2, 32'h0);

    // First write after reset release lands on the next edge
    setWrite(1'b1, 5'd7, 32'h0000_0077);
    tick();
    setWrite(1'b0, '0, '0);
    setRead(5'd7, 5'd0);
    checkEq("first_wr_r7", bus.ReadOut1, 32'h0000_0077);
    checkEq("first_wr_r0", bus.ReadOut2, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/read_and_write.md
READ_AND_WRITE -- requirements
Module: read_and_write

Interface
REQ-001 Parameter DATA_W, default 32, register data width in bits.
REQ-002 Parameter ADDR_W, default 5, register-number width; register count SHALL be 2**ADDR_W (32 by default).
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 Clk  input  1  rising-edge clock for all register writes.
REQ-005 ResetN  input  1  asynchronous active-low reset.
REQ-006 ReadRegNum1  input  ADDR_W  register number selected for read port 1.
REQ-007 ReadRegNum2  input  ADDR_W  register number selected for read port 2.
REQ-008 ReadOut1  output  DATA_W  contents of register ReadRegNum1.
REQ-009 ReadOut2  output  DATA_W  contents of register ReadRegNum2.
REQ-010 WriteEn  input  1  write enable, sampled on rising Clk.
REQ-011 WriteRegNum  input  ADDR_W  destination register number for a write.
REQ-012 RegData  input  DATA_W  write data.

Function
REQ-013 Storage SHALL be 2**ADDR_W registers of DATA_W bits each.
REQ-014 Both read ports SHALL be combinational (zero-cycle latency) and fully independent; both may address the same register.
REQ-015 On a rising Clk edge with WriteEn=1 and ResetN=1, register[WriteRegNum] SHALL take RegData; new value visible on reads from that edge onward.
REQ-016 WriteEn=0 SHALL leave all registers unchanged.
REQ-017 Register 0 SHALL be hardwired: reads always return 0; writes to register 0 SHALL be ignored.
REQ-018 Exactly one register SHALL change per write; all others SHALL hold.
REQ-019 Read address equal to the write address in the same cycle, bypass disabled: read SHALL return the old value until the clock edge.
REQ-020 No handshake; a write SHALL be accepted every cycle WriteEn=1.

Reset
REQ-021 ResetN=0 SHALL clear every register to 0 immediately, independent of Clk.
REQ-022 While ResetN=0, writes SHALL be ignored; ReadOut1/ReadOut2 SHALL read 0.
REQ-023 Reset asserted mid-write SHALL win; the register SHALL end at 0.
REQ-024 After ResetN deasserts, the first write SHALL occur on the next rising Clk edge with WriteEn=1.

Configuration
REQ-025 Macro REGFILE_BYPASS_EN defined: when WriteEn=1, WriteRegNum!=0, ResetN=1 and a read port address equals WriteRegNum, that port SHALL output RegData combinationally in the same cycle.
REQ-026 Macro REGFILE_BYPASS_EN undefined: no forwarding; behaviour per REQ-019.

Verification
REQ-027 Reset, then ReadRegNum1=9, ReadRegNum2=28 -> ReadOut1=0, ReadOut2=0.
REQ-028 WriteEn=1, WriteRegNum=4, RegData=75, one Clk edge, ReadRegNum1=4 -> ReadOut1=75; ReadRegNum2=28 -> ReadOut2=0.
REQ-029 WriteEn=1, WriteRegNum=0, RegData=0xFFFFFFFF, one Clk edge, read register 0 on both ports -> 0 on both.
REQ-030 Write 0xDEADBEEF to register 31, then WriteEn=0 with RegData=0x12345678 for 3 edges -> ReadOut1 stays 0xDEADBEEF for ReadRegNum1=31.
REQ-031 Register 4 holds 75; same cycle WriteEn=1, WriteRegNum=4, RegData=99, ReadRegNum1=4, before edge -> 99 with REGFILE_BYPASS_EN, 75 without; 99 after edge in both builds.
REQ-032 Registers 4 and 9 written non-zero; pulse ResetN low between clock edges -> both read 0 immediately, no clock required.
